reorder_buffer_p: RTL and testbench

REORDER_BUFFER_P -- requirements
Module: reorder_buffer_p

---
 rtl/reorder_buffer_p.sv | 260 ++++++++++++++++++++++++++
 tb/tb_reorder_buffer_p.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_p.sv
// reorder_buffer_p: in-order retirement buffer for an out-of-order core.
// Entries are allocated at tail by decode, completed out of order by the
// writeback ports and the load/store buffer, and retired one per cycle from
// head through registered commit pulses.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable, holds all state)
//   dec_*          allocation request from decode
//   wb_*           WB_PORTS result writeback ports (lower index wins on equal ids)
//   lsb_*          store address/data completion; mem_busy stalls store commit
//   q1_*/q2_*      operand lookup by entry id (combinational)
//   full_out, empty_out, alloc_id_out   status (combinational from registers)
//   rf_commit, mem_store, pred_update, flush_out, halt_out and commit data
//                  registered commit outputs
//
// Configuration macro ROB_WB_BYPASS_EN: when defined, lookups forward
// same-cycle writebacks and ready allocations; otherwise they see stored state.

module reorder_buffer_p #(
    parameter int unsigned DEPTH_WIDTH = 4,
    parameter int unsigned WB_PORTS    = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            dec_valid,
    input  logic [2:0]                      dec_type,
    input  logic [4:0]                      dec_rd,
    input  logic [31:0]                     dec_value,
    input  logic                            dec_ready,
    input  logic [31:0]                     dec_pc,
    input  logic [31:0]                     dec_pred_target,
    input  logic                            dec_pred_taken,
    input  logic [WB_PORTS-1:0]             wb_valid,
    input  logic [WB_PORTS*DEPTH_WIDTH-1:0] wb_id,
    input  logic [WB_PORTS*32-1:0]          wb_value,
    input  logic                            lsb_valid,
    input  logic [DEPTH_WIDTH-1:0]          lsb_id,
    input  logic [31:0]                     lsb_addr,
    input  logic [31:0]                     lsb_data,
    input  logic                            mem_busy,
    input  logic [DEPTH_WIDTH-1:0]          q1_id,
    input  logic [DEPTH_WIDTH-1:0]          q2_id,
    output logic                            q1_found,
    output logic                            q2_found,
    output logic [31:0]                     q1_value,
    output logic [31:0]                     q2_value,
    output logic                            full_out,
    output logic                            empty_out,
    output logic [DEPTH_WIDTH-1:0]          alloc_id_out,
    output logic                            rf_commit,
    output logic                            mem_store,
    output logic                            pred_update,
    output logic                            flush_out,
    output logic                            halt_out,
    output logic [4:0]                      rd_out,
    output logic [31:0]                     value_out,
    output logic [DEPTH_WIDTH-1:0]          commit_id_out,
    output logic [1:0]                      store_size_out,
    output logic [31:0]                     addr_out,
    output logic [31:0]                     pc_out,
    output logic                            taken_out,
    output logic [31:0]                     target_out
);

    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
    localparam int unsigned CW    = DEPTH_WIDTH + 1;

    localparam logic [2:0] T_STORE_B = 3'd0;
    localparam logic [2:0] T_STORE_H = 3'd1;
    localparam logic [2:0] T_STORE_W = 3'd2;
    localparam logic [2:0] T_REG     = 3'd3;
    localparam logic [2:0] T_JALR    = 3'd4;
    localparam logic [2:0] T_BRANCH  = 3'd5;
    localparam logic [2:0] T_EXIT    = 3'd6;

    logic [DEPTH_WIDTH-1:0] head;
    logic [DEPTH_WIDTH-1:0] tail;
    logic [CW-1:0]          count;
    logic [DEPTH-1:0]       ent_ready;
    logic [DEPTH-1:0]       ready_nxt;

    logic [2:0]  ent_type   [DEPTH];
    logic [4:0]  ent_rd     [DEPTH];
    logic [31:0] ent_value  [DEPTH];
    logic [31:0] ent_pc     [DEPTH];
    logic [31:0] ent_target [DEPTH];
    logic        ent_ptaken [DEPTH];
    logic [31:0] ent_addr   [DEPTH];

    logic [2:0]  h_type;
    logic [31:0] h_value;
    logic [31:0] h_pc;
    logic [31:0] h_target;
    logic        h_ptaken;
    logic        h_store;
    logic        alloc_c;
    logic        commit_c;

    assign full_out     = (count == CW'(DEPTH));
    assign empty_out    = (count == '0);
    assign alloc_id_out = tail;

    assign h_type   = ent_type[head];
    assign h_value  = ent_value[head];
    assign h_pc     = ent_pc[head];
    assign h_target = ent_target[head];
    assign h_ptaken = ent_ptaken[head];
    assign h_store  = (h_type == T_STORE_B) || (h_type == T_STORE_H) || (h_type == T_STORE_W);

    // Nothing moves in the cycle that services a flush, nor after EXIT retires.
    assign alloc_c  = dec_valid && !full_out && !flush_out && !halt_out;
    assign commit_c = (count != '0) && ent_ready[head] && !flush_out && !halt_out
                      && !(h_store && mem_busy);

    // Ready flags: retire clears head, then completions, then the new entry.
    always_comb begin
        ready_nxt = ent_ready;
        if (commit_c) begin
            ready_nxt[head] = 1'b0;
        end
        for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
            if (wb_valid[p]) begin
                ready_nxt[wb_id[p*DEPTH_WIDTH +: DEPTH_WIDTH]] = 1'b1;
            end
        end
        if (lsb_valid) begin
            ready_nxt[lsb_id] = 1'b1;
        end
        if (alloc_c) begin
            ready_nxt[tail] = dec_ready;
        end
    end

    // Entry payload storage; descending port order lets port 0 land last.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush_out) begin
            for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
                if (wb_valid[p]) begin
                    ent_value[wb_id[p*DEPTH_WIDTH +: DEPTH_WIDTH]] <= wb_value[p*32 +: 32];
                end
            end
            if (lsb_valid) begin
                ent_value[lsb_id] <= lsb_data;
                ent_addr[lsb_id]  <= lsb_addr;
            end
            if (alloc_c) begin
                ent_type[tail]   <= dec_type;
                ent_rd[tail]     <= dec_rd;
                ent_value[tail]  <= dec_value;
                ent_pc[tail]     <= dec_pc;
                ent_target[tail] <= dec_pred_target;
                ent_ptaken[tail] <= dec_pred_taken;
            end
        end
    end

    // Pointers, occupancy and registered commit outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ent_ready      <= '0;
            rf_commit      <= 1'b0;
            mem_store      <= 1'b0;
            pred_update    <= 1'b0;
            flush_out      <= 1'b0;
            halt_out       <= 1'b0;
            rd_out         <= '0;
            value_out      <= '0;
            commit_id_out  <= '0;
            store_size_out <= '0;
            addr_out       <= '0;
            pc_out         <= '0;
            taken_out      <= 1'b0;
            target_out     <= '0;
        end else if (rdy_in) begin
            rf_commit   <= 1'b0;
            mem_store   <= 1'b0;
            pred_update <= 1'b0;
            flush_out   <= 1'b0;
            if (flush_out) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                ent_ready <= '0;
            end else begin
                ent_ready <= ready_nxt;
                count     <= count + CW'(alloc_c) - CW'(commit_c);
                if (alloc_c) begin
                    tail <= tail + DEPTH_WIDTH'(1);
                end
                if (commit_c) begin
                    head          <= head + DEPTH_WIDTH'(1);
                    commit_id_out <= head;
                    case (h_type)
                        T_REG: begin
                            rf_commit <= 1'b1;
                            rd_out    <= ent_rd[head];
                            value_out <= h_value;
                        end
                        T_JALR: begin
                            rf_commit <= 1'b1;
                            rd_out    <= ent_rd[head];
                            value_out <= h_pc + 32'd4;
                            if (h_value != h_target) begin
                                flush_out  <= 1'b1;
                                target_out <= h_value;
                            end
                        end
                        T_BRANCH: begin
                            pred_update <= 1'b1;
                            pc_out      <= h_pc;
                            taken_out   <= h_value[0];
                            if (h_value[0] != h_ptaken) begin
                                flush_out  <= 1'b1;
                                target_out <= h_value[0] ? h_target : h_pc + 32'd4;
                            end
                        end
                        T_STORE_B, T_STORE_H, T_STORE_W: begin
                            mem_store      <= 1'b1;
                            store_size_out <= h_type[1:0];
                            addr_out       <= ent_addr[head];
                            value_out      <= h_value;
                        end
                        T_EXIT: begin
                            halt_out <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Operand lookup: {found, value} for one entry id.
    function automatic logic [32:0] lookup(input logic [DEPTH_WIDTH-1:0] id);
        logic [32:0] r;
        r = {ent_ready[id], ent_value[id]};
`ifdef ROB_WB_BYPASS_EN
        if (alloc_c && dec_ready && (tail == id)) begin
            r = {1'b1, dec_value};
        end
        for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_id[p*DEPTH_WIDTH +: DEPTH_WIDTH] == id)) begin
                r = {1'b1, wb_value[p*32 +: 32]};
            end
        end
`endif
        return r;
    endfunction

    always_comb begin
        {q1_found, q1_value} = lookup(q1_id);
        {q2_found, q2_value} = lookup(q2_id);
    end

endmodule

// File: tb/tb_reorder_buffer_p.sv
module tb_reorder_buffer_p;

    localparam int unsigned DW  = 4;
    localparam int unsigned WBP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_in, rdy_in;
    logic            dec_valid, dec_ready, dec_pred_taken;
    logic [2:0]      dec_type;
    logic [4:0]      dec_rd;
    logic [31:0]     dec_value, dec_pc, dec_pred_target;
    logic [WBP-1:0]  wb_valid;
    logic [WBP*DW-1:0] wb_id;
    logic [WBP*32-1:0] wb_value;
    logic            lsb_valid, mem_busy;
    logic [DW-1:0]   lsb_id, q1_id, q2_id;
    logic [31:0]     lsb_addr, lsb_data;
    logic            q1_found, q2_found;
    logic [31:0]     q1_value, q2_value;
    logic            full_out, empty_out;
    logic [DW-1:0]   alloc_id_out, commit_id_out;
    logic            rf_commit, mem_store, pred_update, flush_out, halt_out, taken_out;
    logic [4:0]      rd_out;
    logic [31:0]     value_out, addr_out, pc_out, target_out;
    logic [1:0]      store_size_out;

    reorder_buffer_p #(.DEPTH_WIDTH(DW), .WB_PORTS(WBP)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_valid(dec_valid), .dec_type(dec_type), .dec_rd(dec_rd),
        .dec_value(dec_value), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .dec_pred_target(dec_pred_target), .dec_pred_taken(dec_pred_taken),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
        .lsb_valid(lsb_valid), .lsb_id(lsb_id), .lsb_addr(lsb_addr),
        .lsb_data(lsb_data), .mem_busy(mem_busy),
        .q1_id(q1_id), .q2_id(q2_id), .q1_found(q1_found), .q2_found(q2_found),
        .q1_value(q1_value), .q2_value(q2_value),
        .full_out(full_out), .empty_out(empty_out), .alloc_id_out(alloc_id_out),
        .rf_commit(rf_commit), .mem_store(mem_store), .pred_update(pred_update),
        .flush_out(flush_out), .halt_out(halt_out), .rd_out(rd_out),
        .value_out(value_out), .commit_id_out(commit_id_out),
        .store_size_out(store_size_out), .addr_out(addr_out), .pc_out(pc_out),
        .taken_out(taken_out), .target_out(target_out)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rdy_in = 1'b1; dec_valid = 1'b0; dec_type = 3'd3; dec_rd = '0; dec_value = '0;
        dec_ready = 1'b0; dec_pc = '0; dec_pred_target = '0; dec_pred_taken = 1'b0;
        wb_valid = '0; wb_id = '0; wb_value = '0;
        lsb_valid = 1'b0; lsb_id = '0; lsb_addr = '0; lsb_data = '0; mem_busy = 1'b0;
        q1_id = '0; q2_id = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        rdy_in = 1'b0;   // reset must win over a held enable
        step();
        step();
        rst_in = 1'b0;
        rdy_in = 1'b1;
    endtask

    // Single-entry commit scenarios.
    typedef struct {
        string       name;
        logic [2:0]  typ;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] val;
        logic        e_rf;
        logic        e_pu;
        logic        e_fl;
        logic [31:0] e_value;
        logic        e_taken;
        logic [31:0] e_target;
    } vec_t;

    vec_t vecs[7];

    // Reference model for the randomized phase: program-order id queue plus
    // per-id completion state.
    int          mq[$];
    bit          m_ready [16];
    logic [31:0] m_val   [16];
    logic [4:0]  m_rd    [16];
    int          m_next;
    logic        e_rf;
    logic [3:0]  e_id;
    logic [31:0] e_val;
    logic [4:0]  e_rd;

    task automatic lookup_check(input string name, input int id, input logic found,
                                input logic [31:0] value);
        logic        ef;
        logic [31:0] ev;
        ef = m_ready[id];
        ev = m_val[id];
`ifdef ROB_WB_BYPASS_EN
        if (dec_valid && mq.size() < 16 && dec_ready && m_next == id) begin
            ef = 1'b1; ev = dec_value;
        end
        if (wb_valid[1] && int'(wb_id[7:4]) == id) begin
            ef = 1'b1; ev = wb_value[63:32];
        end
        if (wb_valid[0] && int'(wb_id[3:0]) == id) begin
            ef = 1'b1; ev = wb_value[31:0];
        end
`endif
        check({name, "_found"}, 32'(found), 32'(ef));
        if (ef) check({name, "_value"}, value, ev);
    endtask

    initial begin
        int got, wbi, nid, seen, nrf;

        vecs[0] = '{"reg",      3'd3, 32'h0,   32'h0,   1'b0, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h1234, 1'b0, 32'h0};
        vecs[1] = '{"jalr_ok",  3'd4, 32'h40,  32'h80,  1'b0, 32'h80,   1'b1, 1'b0, 1'b0, 32'h44,   1'b0, 32'h0};
        vecs[2] = '{"jalr_mis", 3'd4, 32'h40,  32'h80,  1'b0, 32'h90,   1'b1, 1'b0, 1'b1, 32'h44,   1'b0, 32'h90};
        vecs[3] = '{"br_nt_t",  3'd5, 32'h100, 32'h200, 1'b0, 32'h1,    1'b0, 1'b1, 1'b1, 32'h0,    1'b1, 32'h200};
        vecs[4] = '{"br_t_nt",  3'd5, 32'h100, 32'h200, 1'b1, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0,    1'b0, 32'h104};
        vecs[5] = '{"br_t_t",   3'd5, 32'h300, 32'h400, 1'b1, 32'h1,    1'b0, 1'b1, 1'b0, 32'h0,    1'b1, 32'h0};
        vecs[6] = '{"br_nt_nt", 3'd5, 32'h300, 32'h400, 1'b0, 32'h2,    1'b0, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};

        clear_inputs();
        do_reset();

        // Reset state
        check("rst_empty", 32'(empty_out), 1);
        check("rst_full", 32'(full_out), 0);
        check("rst_alloc_id", 32'(alloc_id_out), 0);
        check("rst_pulses", {27'd0, rf_commit, mem_store, pred_update, flush_out, halt_out}, 0);
        check("rst_value", value_out, 0);
        check("rst_target", target_out, 0);

        // Fill all 16 entries, then a 17th request that must be ignored
        for (int i = 0; i < 16; i++) begin
            dec_valid = 1'b1; dec_type = 3'd3; dec_rd = 5'(i + 1); dec_ready = 1'b0;
            step();
        end
        check("fill_full", 32'(full_out), 1);
        check("fill_alloc_id", 32'(alloc_id_out), 0);
        step();
        dec_valid = 1'b0;
        check("fill17_full", 32'(full_out), 1);
        check("fill17_alloc_id", 32'(alloc_id_out), 0);
        got = 0; wbi = 0;
        for (int c = 0; c < 60 && got < 16; c++) begin
            wb_valid = '0;
            if (wbi < 16) begin
                wb_valid = 2'b11;
                wb_id    = {4'(wbi + 1), 4'(wbi)};
                wb_value = {32'(1000 + wbi + 1), 32'(1000 + wbi)};
                wbi += 2;
            end
            step();
            if (rf_commit) begin
                check("fill_cid", 32'(commit_id_out), 32'(got));
                check("fill_val", value_out, 32'(1000 + got));
                check("fill_rd", 32'(rd_out), 32'(got + 1));
                got++;
            end
        end
        wb_valid = '0;
        check("fill_ncommit", 32'(got), 16);
        check("fill_empty", 32'(empty_out), 1);

        // Wrap: interleaved single allocate / commit
        for (int i = 0; i < 20; i++) begin
            dec_valid = 1'b1; dec_type = 3'd3; dec_ready = 1'b1; dec_value = 32'(i);
            step();
            dec_valid = 1'b0;
            check("wrap_pulse_end", 32'(rf_commit), 0);
            check("wrap_alloc_id", 32'(alloc_id_out), 32'((i + 1) % 16));
            step();
            check("wrap_commit", 32'(rf_commit), 1);
            check("wrap_cid", 32'(commit_id_out), 32'(i % 16));
        end
        nid = 4;

        // Table of single-entry commits
        foreach (vecs[v]) begin
            dec_valid = 1'b1; dec_type = vecs[v].typ; dec_pc = vecs[v].pc;
            dec_pred_target = vecs[v].tgt; dec_pred_taken = vecs[v].ptk;
            dec_ready = 1'b0; dec_rd = 5'd7;
            step();
            dec_valid = 1'b0;
            wb_valid = 2'b01; wb_id = {4'd0, 4'(nid)}; wb_value = {32'd0, vecs[v].val};
            step();
            wb_valid = '0;
            seen = 0;
            for (int c = 0; c < 5; c++) begin
                step();
                if (rf_commit || pred_update) begin
                    seen = 1;
                    break;
                end
            end
            check({vecs[v].name, "_seen"}, 32'(seen), 1);
            check({vecs[v].name, "_rf"}, 32'(rf_commit), 32'(vecs[v].e_rf));
            check({vecs[v].name, "_pu"}, 32'(pred_update), 32'(vecs[v].e_pu));
            check({vecs[v].name, "_flush"}, 32'(flush_out), 32'(vecs[v].e_fl));
            check({vecs[v].name, "_cid"}, 32'(commit_id_out), 32'(nid));
            if (vecs[v].e_rf) check({vecs[v].name, "_value"}, value_out, vecs[v].e_value);
            if (vecs[v].e_pu) begin
                check({vecs[v].name, "_pc"}, pc_out, vecs[v].pc);
                check({vecs[v].name, "_taken"}, 32'(taken_out), 32'(vecs[v].e_taken));
            end
            if (vecs[v].e_fl) check({vecs[v].name, "_target"}, target_out, vecs[v].e_target);
            step();
            check({vecs[v].name, "_pulse_end"}, {29'd0, rf_commit, pred_update, flush_out}, 0);
            check({vecs[v].name, "_empty"}, 32'(empty_out), 1);
            if (vecs[v].e_fl) nid = 0;
            else nid = (nid + 1) % 16;
            check({vecs[v].name, "_alloc_id"}, 32'(alloc_id_out), 32'(nid));
        end

        // Store stalls while memory is busy
        dec_valid = 1'b1; dec_type = 3'd2; dec_ready = 1'b0;
        step();
        dec_valid = 1'b0;
        lsb_valid = 1'b1; lsb_id = 4'(nid); lsb_addr = 32'hA000; lsb_data = 32'hBEEF; mem_busy = 1'b1;
        step();
        lsb_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("st_busy_nostore", 32'(mem_store), 0);
        end
        mem_busy = 1'b0;
        step();
        check("st_store", 32'(mem_store), 1);
        check("st_rf", 32'(rf_commit), 0);
        check("st_addr", addr_out, 32'hA000);
        check("st_data", value_out, 32'hBEEF);
        check("st_size", 32'(store_size_out), 2);
        check("st_cid", 32'(commit_id_out), 32'(nid));
        step();
        check("st_pulse_end", 32'(mem_store), 0);

        // Lookup of a same-cycle writeback
        do_reset();
        check("rst2_values", value_out, 0);
        for (int i = 0; i < 6; i++) begin
            dec_valid = 1'b1; dec_type = 3'd3; dec_ready = 1'b0;
            step();
        end
        dec_valid = 1'b0;
        wb_valid = 2'b10; wb_id = {4'd5, 4'd0}; wb_value = {32'hDEAD, 32'h0};
        q1_id = 4'd5; q2_id = 4'd3;
        #1;
`ifdef ROB_WB_BYPASS_EN
        check("byp_q1_found", 32'(q1_found), 1);
        check("byp_q1_value", q1_value, 32'hDEAD);
`else
        check("nobyp_q1_found", 32'(q1_found), 0);
`endif
        check("q2_notready", 32'(q2_found), 0);
        step();
        wb_valid = '0;
        #1;
        check("q1_found_later", 32'(q1_found), 1);
        check("q1_value_later", q1_value, 32'hDEAD);

        // EXIT halts further commits and allocations
        dec_valid = 1'b1; dec_type = 3'd6; dec_ready = 1'b1;
        step();
        dec_type = 3'd3; dec_value = 32'h77;
        step();
        dec_valid = 1'b0;
        nrf = 0;
        for (int c = 0; c < 25; c++) begin
            wb_valid = '0;
            if (c < 5) begin
                wb_valid = 2'b01; wb_id = {4'd0, 4'(c)}; wb_value = {32'd0, 32'(c)};
            end
            step();
            if (rf_commit) nrf++;
        end
        wb_valid = '0;
        check("exit_rf_count", 32'(nrf), 6);
        check("exit_halt", 32'(halt_out), 1);
        check("exit_not_empty", 32'(empty_out), 0);
        check("exit_alloc_id", 32'(alloc_id_out), 8);
        dec_valid = 1'b1;
        step();
        step();
        dec_valid = 1'b0;
        check("exit_no_alloc", 32'(alloc_id_out), 8);
        check("exit_halt_sticky", 32'(halt_out), 1);

        // rdy_in low freezes state and outputs
        do_reset();
        check("rst3_halt", 32'(halt_out), 0);
        rdy_in = 1'b0; dec_valid = 1'b1; dec_type = 3'd3; dec_ready = 1'b1;
        step();
        step();
        check("hold_alloc_id", 32'(alloc_id_out), 0);
        check("hold_empty", 32'(empty_out), 1);
        rdy_in = 1'b1;
        step();
        dec_valid = 1'b0;
        check("rdy_alloc_id", 32'(alloc_id_out), 1);
        step();
        check("rdy_commit", 32'(rf_commit), 1);
        rdy_in = 1'b0;
        step();
        check("hold_pulse", 32'(rf_commit), 1);
        rdy_in = 1'b1;
        step();
        check("release_pulse", 32'(rf_commit), 0);
        check("release_empty", 32'(empty_out), 1);

        // Randomized REG traffic against the reference model
        clear_inputs();
        do_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) m_ready[i] = 1'b0;
        m_next = 0; e_rf = 1'b0; e_id = '0; e_val = '0; e_rd = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit alloc_ok;
            rdy_in    = ($urandom_range(0, 9) != 0);
            dec_valid = 1'($urandom_range(0, 1));
            dec_type  = 3'd3;
            dec_ready = ($urandom_range(0, 3) == 0);
            dec_value = $urandom;
            dec_rd    = 5'($urandom);
            wb_valid  = '0;
            for (int p = 0; p < 2; p++) begin
                if (mq.size() > 0 && $urandom_range(0, 2) == 0) begin
                    wb_valid[p] = 1'b1;
                    wb_id[p*4 +: 4] = 4'(mq[$urandom_range(0, mq.size() - 1)]);
                    wb_value[p*32 +: 32] = $urandom;
                end
            end
            if (wb_valid == 2'b11 && $urandom_range(0, 3) == 0) wb_id[7:4] = wb_id[3:0];
            q1_id = 4'($urandom);
            q2_id = 4'($urandom);
            #1;
            lookup_check("rnd_q1", int'(q1_id), q1_found, q1_value);
            lookup_check("rnd_q2", int'(q2_id), q2_found, q2_value);
            @(posedge clk);
            if (rdy_in) begin
                alloc_ok = dec_valid && (mq.size() < 16);
                e_rf = 1'b0;
                if (mq.size() > 0 && m_ready[mq[0]]) begin
                    int id;
                    id = mq.pop_front();
                    e_rf = 1'b1; e_id = 4'(id); e_val = m_val[id]; e_rd = m_rd[id];
                    m_ready[id] = 1'b0;
                end
                if (wb_valid[1]) begin
                    m_ready[wb_id[7:4]] = 1'b1; m_val[wb_id[7:4]] = wb_value[63:32];
                end
                if (wb_valid[0]) begin
                    m_ready[wb_id[3:0]] = 1'b1; m_val[wb_id[3:0]] = wb_value[31:0];
                end
                if (alloc_ok) begin
                    m_ready[m_next] = dec_ready; m_val[m_next] = dec_value; m_rd[m_next] = dec_rd;
                    mq.push_back(m_next);
                    m_next = (m_next + 1) % 16;
                end
            end
            #1;
            check("rnd_rf", 32'(rf_commit), 32'(e_rf));
            check("rnd_cid", 32'(commit_id_out), 32'(e_id));
            check("rnd_val", value_out, e_val);
            check("rnd_rd", 32'(rd_out), 32'(e_rd));
            check("rnd_full", 32'(full_out), 32'(mq.size() == 16));
            check("rnd_empty", 32'(empty_out), 32'(mq.size() == 0));
            check("rnd_alloc_id", 32'(alloc_id_out), 32'(m_next));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
